// File: rtl/mem_port_arbiter_pkg.sv
// Shared RAM-port command encodings and arbiter state type.
// Latency: none (declarations only).
// Backpressure: none.
package mem_pkg;

    localparam logic [1:0] MREAD  = 2'b00;
    localparam logic [1:0] MNONE  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    // The reserved encoding 11 behaves exactly like MNONE.
    function automatic logic [1:0] norm_cmd(input logic [1:0] c);
        return ((c == MREAD) || (c == MWRITE)) ? c : MNONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles both requester handshakes and the RAM port of the arbiter.
// Latency: none (wiring only).
// Backpressure: req is held until done; no other flow control.
interface mem_port_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
) ();
    logic          req0, req1;
    logic [1:0]    cmd0, cmd1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          done0, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    gnt;
    logic          busy;

    // Arbiter side.
    modport slave (
        input  req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output done0, done1, rdata0, rdata1, mem_cmd, mem_addr, mem_wdata, gnt, busy
    );

    // Requesters plus RAM side.
    modport master (
        output req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  done0, done1, rdata0, rdata1, mem_cmd, mem_addr, mem_wdata, gnt, busy
    );
endinterface

// File: rtl/mem_port_arbiter_arb.sv
// Two-way request picker, round-robin or fixed priority to requester 0.
// Latency: combinational winner; pointer moves on the edge where advance is high.
// Backpressure: losers simply keep requesting; nothing is dropped.
module arb_rr2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       advance,
    input  logic       fixed,
    output logic [1:0] winner
);
    // ptr_q = 0 means requester 0 is preferred on a tie.
    logic ptr_q, ptr_d;

    // Pick the winner; on a tie the pointer decides unless fixed priority.
    always_comb begin
        winner = 2'b00;
        if (req0 && req1) begin
            winner = (fixed || !ptr_q) ? 2'b01 : 2'b10;
        end else if (req0) begin
            winner = 2'b01;
        end else if (req1) begin
            winner = 2'b10;
        end
    end

    // After any grant, prefer the requester that did not just win.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && (winner != 2'b00)) begin
            ptr_d = winner[0];
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between two req/done requesters.
// Latency: write/none done 2 cycles after grant edge, read done 2+READ_LAT.
// Backpressure: loser waits with req held; inputs ignored outside IDLE.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int AW        = 9,
    parameter int DW        = 16,
    parameter int READ_LAT  = 1,
    parameter int FIXED_PRI = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);
    localparam int             CW       = $clog2(READ_LAT + 1);
    localparam logic [CW-1:0]  LAT_LOAD = CW'(READ_LAT - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mem_cmd_q, mem_cmd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic [1:0]    winner;
    logic          advance;

    assign advance = (state_q == ST_IDLE) && (bus.req0 || bus.req1);

    arb_rr2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req0    (bus.req0),
        .req1    (bus.req1),
        .advance (advance),
        .fixed   (FIXED_PRI != 0),
        .winner  (winner)
    );

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_cmd_d   = mem_cmd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (advance) begin
                    gnt_d  = winner;
                    busy_d = 1'b1;
                    if (winner[1]) begin
                        mem_cmd_d   = norm_cmd(bus.cmd1);
                        mem_addr_d  = bus.addr1;
                        mem_wdata_d = bus.wdata1;
                    end else begin
                        mem_cmd_d   = norm_cmd(bus.cmd0);
                        mem_addr_d  = bus.addr0;
                        mem_wdata_d = bus.wdata0;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_cmd_q == MREAD) begin
                    cnt_d   = LAT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    // Write is sampled by the RAM on this edge; MNONE never touched it.
                    mem_cmd_d = MNONE;
                    done0_d   = gnt_q[0];
                    done1_d   = gnt_q[1];
                    state_d   = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (gnt_q[0]) rdata0_d = bus.mem_rdata;
                    if (gnt_q[1]) rdata1_d = bus.mem_rdata;
                    mem_cmd_d = MNONE;
                    done0_d   = gnt_q[0];
                    done1_d   = gnt_q[1];
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_cmd_q   <= MNONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            gnt_q       <= 2'b00;
            busy_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_cmd_q   <= mem_cmd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign bus.mem_cmd   = mem_cmd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
endmodule
